// File: rtl/sprite_pixel_source_if.sv
// Command, sprite-memory and pixel-stream signals of the sprite pixel source.
// The master side is the pixel source itself; the slave side is its environment.
interface sprite_pixel_source_if #(
  parameter int SPRITE_ADDR_W = 12
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [10:0]              cmd_x;
  logic [10:0]              cmd_y;
  logic [10:0]              cmd_w_m1;
  logic [10:0]              cmd_h_m1;
  logic [SPRITE_ADDR_W-1:0] cmd_base;
  logic                     cmd_key_en;
  logic [7:0]               cmd_key;
  logic                     rom_en;
  logic [SPRITE_ADDR_W-1:0] rom_addr;
  logic [7:0]               rom_data;
  logic [10:0]              pixel_x;
  logic [10:0]              pixel_y;
  logic [7:0]               pixel_data;
  logic                     draw;
  logic                     pixel_valid;
  logic                     pixel_ready;
  logic [10:0]              width;
  logic [10:0]              height;
  logic                     busy;
  logic                     done;

  modport master (
    input  cmd_valid, cmd_x, cmd_y, cmd_w_m1, cmd_h_m1, cmd_base, cmd_key_en, cmd_key,
    input  rom_data, pixel_ready,
    output cmd_ready, rom_en, rom_addr, pixel_x, pixel_y, pixel_data, draw, pixel_valid,
    output width, height, busy, done
  );

  modport slave (
    output cmd_valid, cmd_x, cmd_y, cmd_w_m1, cmd_h_m1, cmd_base, cmd_key_en, cmd_key,
    output rom_data, pixel_ready,
    input  cmd_ready, rom_en, rom_addr, pixel_x, pixel_y, pixel_data, draw, pixel_valid,
    input  width, height, busy, done
  );
endinterface

// File: rtl/sprite_pixel_source.sv
// Fetches one rectangle of 8-bit palette indices from sprite memory and streams the
// pixels in raster order with screen coordinates and a key/clip draw flag.
module sprite_pixel_source #(
  parameter int SPRITE_ADDR_W = 12,
  parameter int SCREEN_W      = 800,
  parameter int SCREEN_H      = 600
) (
  input  logic                  clk,
  input  logic                  reset,
  sprite_pixel_source_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [11:0] SCREEN_W12 = 12'(SCREEN_W);
  localparam logic [11:0] SCREEN_H12 = 12'(SCREEN_H);
  localparam logic [SPRITE_ADDR_W-1:0] ADDR_ONE = {{(SPRITE_ADDR_W-1){1'b0}}, 1'b1};

  state_t                   state_q, state_d;
  logic [10:0]              x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [10:0]              col_q, col_d, row_q, row_d;
  logic [SPRITE_ADDR_W-1:0] addr_q, addr_d;
  logic                     key_en_q, key_en_d;
  logic [7:0]               key_q, key_d;
  logic                     busy_q, busy_d, done_q, done_d;

  // Tags of the read in flight, aligned with the one-cycle memory latency
  logic                     infl_q, infl_d, infl_last_q, infl_last_d;
  logic [10:0]              infl_col_q, infl_col_d, infl_row_q, infl_row_d;

  // FIFO entry layout: {last, row[10:0], col[10:0], data[7:0]}
  logic [30:0]              fifo_mem [2];
  logic                     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]               count_q, count_d;

  logic                     pv_q, pv_d, draw_q, draw_d, plast_q, plast_d;
  logic [10:0]              px_q, px_d, py_q, py_d;
  logic [7:0]               pd_q, pd_d;

  logic                     hs, pop, push, fetch, fetch_last, head_draw;
  logic [2:0]               occ;
  logic [30:0]              head;
  logic [11:0]              hx, hy;

  always_comb begin
    head       = fifo_mem[rd_ptr_q];
    hx         = {1'b0, x0_q} + {1'b0, head[18:8]};
    hy         = {1'b0, y0_q} + {1'b0, head[29:19]};
    head_draw  = !(key_en_q && (head[7:0] == key_q)) && (hx < SCREEN_W12) && (hy < SCREEN_H12);
    hs         = pv_q && bus.pixel_ready;
    pop        = (!pv_q || bus.pixel_ready) && (count_q != 2'd0);
    push       = infl_q;
    // Occupancy counts the slot freed by this cycle's pop so a fetch can issue every cycle
    occ        = {1'b0, count_q} + {2'b0, infl_q} - {2'b0, pop};
    fetch      = (state_q == RUN) && (occ < 3'd2) && !reset;
    fetch_last = (col_q == w_q) && (row_q == h_q);

    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    key_en_d    = key_en_q;
    key_d       = key_q;
    busy_d      = busy_q;
    done_d      = hs && plast_q;
    infl_d      = fetch;
    infl_col_d  = col_q;
    infl_row_d  = row_q;
    infl_last_d = fetch_last;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
    pv_d        = pv_q;
    px_d        = px_q;
    py_d        = py_q;
    pd_d        = pd_q;
    draw_d      = draw_q;
    plast_d     = plast_q;

    if (pop) begin
      pv_d    = 1'b1;
      px_d    = hx[10:0];
      py_d    = hy[10:0];
      pd_d    = head[7:0];
      draw_d  = head_draw;
      plast_d = head[30];
    end else if (hs) begin
      pv_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          x0_d     = bus.cmd_x;
          y0_d     = bus.cmd_y;
          w_d      = bus.cmd_w_m1;
          h_d      = bus.cmd_h_m1;
          addr_d   = bus.cmd_base;
          key_en_d = bus.cmd_key_en;
          key_d    = bus.cmd_key;
          col_d    = '0;
          row_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (fetch) begin
          addr_d = addr_q + ADDR_ONE;
          if (col_q == w_q) begin
            col_d = '0;
            row_d = row_q + 11'd1;
          end else begin
            col_d = col_q + 11'd1;
          end
          if (fetch_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && plast_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      key_en_q    <= 1'b0;
      key_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      infl_q      <= 1'b0;
      infl_col_q  <= '0;
      infl_row_q  <= '0;
      infl_last_q <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      pv_q        <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
      pd_q        <= '0;
      draw_q      <= 1'b0;
      plast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      key_en_q    <= key_en_d;
      key_q       <= key_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      infl_q      <= infl_d;
      infl_col_q  <= infl_col_d;
      infl_row_q  <= infl_row_d;
      infl_last_q <= infl_last_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pv_q        <= pv_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pd_q        <= pd_d;
      draw_q      <= draw_d;
      plast_q     <= plast_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) fifo_mem[wr_ptr_q] <= {infl_last_q, infl_row_q, infl_col_q, bus.rom_data};
  end

  assign bus.cmd_ready   = (state_q == IDLE) && !reset;
  assign bus.rom_en      = fetch;
  assign bus.rom_addr    = addr_q;
  assign bus.pixel_x     = px_q;
  assign bus.pixel_y     = py_q;
  assign bus.pixel_data  = pd_q;
  assign bus.draw        = draw_q;
  assign bus.pixel_valid = pv_q;
  assign bus.width       = w_q;
  assign bus.height      = h_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_sprite_pixel_source.sv
// Directed bench for sprite_pixel_source: a sprite ROM model, a pixel scoreboard
// filled at command accept, and a negedge monitor that pops it on each handshake.
module tb_sprite_pixel_source;
  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  d;
    logic        draw;
  } pix_t;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] w;
    logic [10:0] h;
    logic [11:0] base;
    logic        key_en;
    logic [7:0]  key;
  } cmd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sprite_pixel_source_if #(.SPRITE_ADDR_W(12)) bus ();

  sprite_pixel_source #(
    .SPRITE_ADDR_W(12),
    .SCREEN_W(800),
    .SCREEN_H(600)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [7:0]  rom [4096];
  pix_t        exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          fetch_total = 0;
  int          hs_total = 0;
  int          fetch_start = 0;
  int          hs_start = 0;
  logic [11:0] exp_base = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_out = '0;

  // Synchronous sprite memory: data one cycle after rom_en
  always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_stall  <= 1'b0;
      fetch_total <= 0;
      hs_total    <= 0;
    end else begin
      if (prev_stall)
        check("stall_hold", {bus.pixel_valid, bus.pixel_x, bus.pixel_y, bus.pixel_data, bus.draw}, prev_out);
      check("outstanding_le2", 32'((fetch_total - hs_total - int'(bus.pixel_valid)) <= 2), 32'd1);
      if (bus.rom_en) begin
        check("rom_addr", {20'b0, bus.rom_addr}, {20'b0, 12'(exp_base + 12'(fetch_total - fetch_start))});
        fetch_total <= fetch_total + 1;
      end
      if (bus.pixel_valid && bus.pixel_ready) begin
        hs_total <= hs_total + 1;
        if (exp_q.size() == 0) begin
          check("extra_pixel", exp_q.size(), 1);
        end else begin
          check("pixel_x", bus.pixel_x, exp_q[0].x);
          check("pixel_y", bus.pixel_y, exp_q[0].y);
          check("pixel_data", bus.pixel_data, exp_q[0].d);
          check("draw", bus.draw, exp_q[0].draw);
          void'(exp_q.pop_front());
        end
      end
      prev_stall <= bus.pixel_valid && !bus.pixel_ready;
      prev_out   <= {bus.pixel_valid, bus.pixel_x, bus.pixel_y, bus.pixel_data, bus.draw};
    end
  end

  function automatic cmd_t mk(input int x, input int y, input int w, input int h,
                              input int base, input int ke, input int key);
    cmd_t c;
    c.x      = 11'(x);
    c.y      = 11'(y);
    c.w      = 11'(w);
    c.h      = 11'(h);
    c.base   = 12'(base);
    c.key_en = (ke != 0);
    c.key    = 8'(key);
    return c;
  endfunction

  task automatic model_push(input cmd_t c);
    pix_t        p;
    logic [11:0] a, xx, yy;
    a = c.base;
    for (int r = 0; r <= int'(c.h); r++) begin
      for (int k = 0; k <= int'(c.w); k++) begin
        xx     = {1'b0, c.x} + 12'(k);
        yy     = {1'b0, c.y} + 12'(r);
        p.x    = xx[10:0];
        p.y    = yy[10:0];
        p.d    = rom[a];
        p.draw = !(c.key_en && (p.d == c.key)) && (xx < 12'd800) && (yy < 12'd600);
        exp_q.push_back(p);
        a = a + 12'd1;
      end
    end
  endtask

  task automatic issue(input cmd_t c, output logic done_seen);
    bus.cmd_x      = c.x;
    bus.cmd_y      = c.y;
    bus.cmd_w_m1   = c.w;
    bus.cmd_h_m1   = c.h;
    bus.cmd_base   = c.base;
    bus.cmd_key_en = c.key_en;
    bus.cmd_key    = c.key;
    bus.cmd_valid  = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    check("cmd_accept", bus.cmd_ready, 1);
    done_seen = bus.done;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    exp_base    = c.base;
    fetch_start = fetch_total;
    hs_start    = hs_total;
    model_push(c);
    $display("cmd x=%0d y=%0d w_m1=%0d h_m1=%0d base=%0h key_en=%0b key=%0h",
             c.x, c.y, c.w, c.h, c.base, c.key_en, c.key);
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating
  task automatic wait_done(input int mode, input int budget);
    int ndone = 0;
    int tail = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
      bus.pixel_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      if (ndone > 0) begin
        tail++;
        if (tail > 3) break;
      end
    end
    check("done_pulses", ndone, 1);
    check("queue_drained", exp_q.size(), 0);
    check("busy_after", bus.busy, 0);
    bus.pixel_ready = 1'b1;
  endtask

  task automatic check_reset_vals();
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rom", {bus.rom_en, bus.rom_addr}, 0);
    check("rst_pixel_valid", bus.pixel_valid, 0);
    check("rst_pixel_fields", {bus.pixel_x, bus.pixel_y, bus.pixel_data, bus.draw}, 0);
    check("rst_width_height", {bus.width, bus.height}, 0);
    check("rst_busy_done", {bus.busy, bus.done}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    logic ds;
    int   lat;

    for (int i = 0; i < 4096; i++) rom[i] = 8'((i * 37 + 11) & 255);
    rom[12'h200] = 8'h00;
    rom[12'h201] = 8'h05;
    rom[12'h202] = 8'h00;
    rom[12'h203] = 8'h07;

    bus.cmd_valid   = 1'b0;
    bus.cmd_x       = '0;
    bus.cmd_y       = '0;
    bus.cmd_w_m1    = '0;
    bus.cmd_h_m1    = '0;
    bus.cmd_base    = '0;
    bus.cmd_key_en  = 1'b0;
    bus.cmd_key     = '0;
    bus.pixel_ready = 1'b1;
    reset           = 1'b1;

    @(posedge clk);
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("ready_after_reset", bus.cmd_ready, 1);

    // 4x2 basic sprite: latency, width/height latch, raster order
    c = mk(10, 20, 3, 1, 'h100, 0, 0);
    issue(c, ds);
    check("width_latched", bus.width, 3);
    check("height_latched", bus.height, 1);
    check("busy_running", bus.busy, 1);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.pixel_valid) break;
      lat++;
    end
    check("first_pixel_latency", lat, 3);
    wait_done(0, 200);

    // colour key on index 0
    c = mk(100, 50, 3, 0, 'h200, 1, 0);
    issue(c, ds);
    wait_done(0, 200);

    // 16x3 with stalling consumer
    c = mk(200, 100, 15, 2, 'h400, 0, 0);
    issue(c, ds);
    wait_done(1, 600);

    // screen-edge clipping
    c = mk(798, 599, 3, 1, 'h500, 0, 0);
    issue(c, ds);
    wait_done(0, 200);

    // 1x1 followed by a back-to-back command
    c = mk(5, 5, 0, 0, 'h600, 0, 0);
    issue(c, ds);
    c = mk(30, 40, 5, 2, 'h700, 0, 0);
    issue(c, ds);
    check("b2b_done_at_accept", ds, 1);
    check("b2b_width", bus.width, 5);
    check("b2b_height", bus.height, 2);
    wait_done(0, 300);

    // reset part-way through a 32-pixel command
    c = mk(300, 300, 7, 3, 'h800, 0, 0);
    issue(c, ds);
    for (int k = 0; k < 100; k++) begin
      if ((hs_total - hs_start) >= 5) break;
      @(posedge clk);
      #1;
    end
    check("abort_progress", 32'((hs_total - hs_start) >= 5), 32'd1);
    reset = 1'b1;
    bus.pixel_ready = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals();
    exp_q.delete();
    reset = 1'b0;
    bus.pixel_ready = 1'b1;
    #1;
    check("ready_after_abort", bus.cmd_ready, 1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
    end
    check("no_stale_pixel", bus.pixel_valid, 0);
    issue(c, ds);
    wait_done(0, 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
